pwm_bank: RTL and testbench

Multi-channel, phase-shifted PWM generator with a byte-stream command port for run-time reconfiguration. It sits between the UART receiver (`rx_dat`/`rx_stb`) and the open-drain PWM pad drivers, replacing the single fixed-offset compare channel. A shared period counter drives `CH` channels, each with its own duty and phase. All new settings are double-buffered and take effect only at the period wrap, so the outputs never produce runt pulses.

---
 rtl/pwm_bank_if.sv | 26 ++
 rtl/pwm_bank.sv | 183 ++++++++++++++++++
 tb/tb_pwm_bank.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_bank_if.sv
// pwm_bank_if: command byte stream in, PWM levels and frame status out.
// master = UART/command side, slave = pwm_bank.
`default_nettype none

interface pwm_bank_if #(
    parameter int CH = 4
);
    logic [7:0]    rx_dat;
    logic          rx_stb;
    logic [CH-1:0] pwm;
    logic          wrap;
    logic          frm_ok;
    logic          frm_err;

    modport master (
        output rx_dat, rx_stb,
        input  pwm, wrap, frm_ok, frm_err
    );

    modport slave (
        input  rx_dat, rx_stb,
        output pwm, wrap, frm_ok, frm_err
    );
endinterface

`default_nettype wire

// File: rtl/pwm_bank.sv
// pwm_bank: CH-channel phase-shifted PWM with double-buffered settings and a 3-byte command parser.
// Optional partial-frame idle timeout is built when PWM_BANK_TIMEOUT_EN is defined.
`default_nettype none

module pwm_bank #(
    parameter int CH          = 4,
    parameter int CW          = 9,
    parameter int PERIOD_RST  = 2**CW - 1,
    parameter int TIMEOUT_CYC = 48000
) (
    input  wire logic  clk,
    input  wire logic  rst,
    pwm_bank_if.slave  bus
);

    localparam logic [CW-1:0] PRST = CW'(PERIOD_RST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      hdr_q, hdr_d;
    logic [7:0]      hi_q, hi_d;
    logic            wr_duty, wr_phase, wr_period;
    logic            frm_ok_d, frm_err_d, frm_ok_q, frm_err_q;
    logic            ch_ok;
    logic            tmo;
    logic [CW-1:0]   val;

    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   period_a_q, period_s_q;
    logic [CW-1:0]   duty_a_q  [CH];
    logic [CW-1:0]   phase_a_q [CH];
    logic [CW-1:0]   duty_s_q  [CH];
    logic [CW-1:0]   phase_s_q [CH];
    logic [CH-1:0]   pwm_d, pwm_q;
    logic            wrap_q;
    logic            commit;

    assign val    = CW'({hi_q, bus.rx_dat});
    assign ch_ok  = {1'b0, hdr_q[5:0]} < 7'(CH);
    assign commit = (cnt_q == period_a_q);

`ifdef PWM_BANK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q <= '0;
        end else if (state_q == S_IDLE || bus.rx_stb || tmo) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + TW'(1);
        end
    end

    // Fires on the TIMEOUT_CYC-th consecutive idle cycle; a strobe that cycle wins.
    assign tmo = (state_q != S_IDLE) && !bus.rx_stb && (idle_q == TW'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            hdr_q     <= '0;
            hi_q      <= '0;
            frm_ok_q  <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            hi_q      <= hi_d;
            frm_ok_q  <= frm_ok_d;
            frm_err_q <= frm_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        hi_d      = hi_q;
        wr_duty   = 1'b0;
        wr_phase  = 1'b0;
        wr_period = 1'b0;
        frm_ok_d  = 1'b0;
        frm_err_d = 1'b0;
        if (tmo) begin
            state_d   = S_IDLE;
            frm_err_d = 1'b1;
        end else if (bus.rx_stb) begin
            case (state_q)
                S_IDLE: begin
                    hdr_d   = bus.rx_dat;
                    state_d = S_HI;
                end
                S_HI: begin
                    hi_d    = bus.rx_dat;
                    state_d = S_LO;
                end
                S_LO: begin
                    state_d = S_IDLE;
                    case (hdr_q[7:6])
                        2'd0:    wr_duty   = ch_ok;
                        2'd1:    wr_phase  = ch_ok;
                        2'd2:    wr_period = 1'b1;
                        default: ;
                    endcase
                    frm_ok_d  = wr_duty | wr_phase | wr_period;
                    frm_err_d = ~frm_ok_d;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Phase-shifted position is folded back into 0..period_a before the duty compare.
    always_comb begin
        logic [CW:0] ph;
        pwm_d = '0;
        ph    = '0;
        for (int c = 0; c < CH; c++) begin
            ph = {1'b0, cnt_q} + {1'b0, phase_a_q[c]};
            if (ph > {1'b0, period_a_q}) begin
                ph = ph - ({1'b0, period_a_q} + (CW+1)'(1));
            end
            pwm_d[c] = (ph < {1'b0, duty_a_q[c]});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            period_a_q <= PRST;
            period_s_q <= PRST;
            pwm_q      <= '0;
            wrap_q     <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                duty_a_q[c]  <= '0;
                phase_a_q[c] <= '0;
                duty_s_q[c]  <= '0;
                phase_s_q[c] <= '0;
            end
        end else begin
            wrap_q <= (cnt_q == '0);
            pwm_q  <= pwm_d;
            if (commit) begin
                cnt_q      <= '0;
                period_a_q <= period_s_q;
                for (int c = 0; c < CH; c++) begin
                    duty_a_q[c]  <= duty_s_q[c];
                    phase_a_q[c] <= (phase_s_q[c] > period_s_q) ? period_s_q : phase_s_q[c];
                end
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            // Shadow writes landing on the commit edge are picked up at the next wrap.
            if (wr_period) begin
                period_s_q <= val;
            end
            for (int c = 0; c < CH; c++) begin
                if (wr_duty && hdr_q[5:0] == 6'(c)) begin
                    duty_s_q[c] <= val;
                end
                if (wr_phase && hdr_q[5:0] == 6'(c)) begin
                    phase_s_q[c] <= val;
                end
            end
        end
    end

    assign bus.pwm     = pwm_q;
    assign bus.wrap    = wrap_q;
    assign bus.frm_ok  = frm_ok_q;
    assign bus.frm_err = frm_err_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed self-checking bench for pwm_bank (CH=4, CW=9).
`default_nettype none

module tb_pwm_bank;

    localparam int CH = 4;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pwm_bank_if #(.CH(CH)) bus ();

    pwm_bank #(
        .CH(CH), .CW(CW), .PERIOD_RST(511), .TIMEOUT_CYC(1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              output logic ok, output logic err);
        bus.rx_dat = b0;
        bus.rx_stb = 1'b1;
        @(negedge clk);
        bus.rx_dat = b1;
        @(negedge clk);
        bus.rx_dat = b2;
        @(negedge clk);
        bus.rx_stb = 1'b0;
        bus.rx_dat = 8'h00;
        ok  = bus.frm_ok;
        err = bus.frm_err;
    endtask

    task automatic wait_wrap(output int n, output bit tmo);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.wrap !== 1'b1 && n < 2000);
        tmo = (bus.wrap !== 1'b1);
    endtask

    task automatic test_reset();
        int bad = 0;
        int wbad = 0;
        bus.rx_dat = 8'h00;
        bus.rx_stb = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.pwm, bus.wrap, bus.frm_ok, bus.frm_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000000", {bus.pwm, bus.wrap, bus.frm_ok, bus.frm_err});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.wrap !== 1'b1) begin
            errors++;
            $display("FAIL first_wrap got %b want 1", bus.wrap);
        end
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (bus.pwm !== 4'b0000) bad++;
            if (bus.wrap !== ((k % 512) == 0)) wbad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_pwm_zero got %0d nonzero samples want 0", bad);
        end
        checks++;
        if (wbad != 0) begin
            errors++;
            $display("FAIL reset_wrap_512 got %0d bad wrap samples want 0", wbad);
        end
    endtask

    task automatic test_duty_phase();
        logic ok, err;
        int n = 0;
        int bad = 0;
        int hc = 0;
        send_frame(8'h01, 8'h00, 8'h80, ok, err);
        checks++;
        if (ok !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL duty_frame_ok got ok=%b err=%b want ok=1 err=0", ok, err);
        end
        send_frame(8'h41, 8'h00, 8'h40, ok, err);
        checks++;
        if (ok !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL phase_frame_ok got ok=%b err=%b want ok=1 err=0", ok, err);
        end
        while (bus.wrap !== 1'b1 && n < 2000) begin
            if (bus.pwm !== 4'b0000) bad++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000 || bad != 0) begin
            errors++;
            $display("FAIL pre_commit_pwm got %0d bad samples (waited %0d) want 0", bad, n);
        end
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            logic [3:0] exp;
            exp = (k < 64 || k >= 448) ? 4'b0010 : 4'b0000;
            if (bus.pwm !== exp) bad++;
            if (bus.pwm[1] === 1'b1) hc++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ch1_pattern got %0d bad samples want 0", bad);
        end
        checks++;
        if (hc != 128) begin
            errors++;
            $display("FAIL ch1_high_count got %0d want 128", hc);
        end
    endtask

    task automatic test_period();
        logic ok, err;
        int n;
        bit tmo;
        int wbad = 0;
        int bad = 0;
        send_frame(8'h80, 8'h00, 8'h63, ok, err);
        checks++;
        if (ok !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL period_frame_ok got ok=%b err=%b want ok=1 err=0", ok, err);
        end
        wait_wrap(n, tmo);
        for (int k = 0; k < 200; k++) begin
            if (bus.wrap !== ((k % 100) == 0)) wbad++;
            @(negedge clk);
        end
        checks++;
        if (tmo || wbad != 0) begin
            errors++;
            $display("FAIL wrap_100 got %0d bad wrap samples (tmo=%0b) want 0", wbad, tmo);
        end
        send_frame(8'h00, 8'h00, 8'hC8, ok, err);
        checks++;
        if (ok !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL ch0_duty_frame_ok got ok=%b err=%b want ok=1 err=0", ok, err);
        end
        wait_wrap(n, tmo);
        for (int k = 0; k < 100; k++) begin
            if (bus.pwm !== 4'b0011) bad++;
            @(negedge clk);
        end
        checks++;
        if (tmo || bad != 0) begin
            errors++;
            $display("FAIL duty_over_period got %0d bad samples (tmo=%0b) want 0", bad, tmo);
        end
    endtask

    task automatic test_invalid();
        logic ok, err;
        int n;
        bit tmo;
        int bad = 0;
        int wbad = 0;
        send_frame(8'h05, 8'h12, 8'h34, ok, err);
        checks++;
        if (ok !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL bad_channel got ok=%b err=%b want ok=0 err=1", ok, err);
        end
        send_frame(8'hC0, 8'h00, 8'h00, ok, err);
        checks++;
        if (ok !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL reserved_cmd got ok=%b err=%b want ok=0 err=1", ok, err);
        end
        wait_wrap(n, tmo);
        wait_wrap(n, tmo);
        for (int k = 0; k < 200; k++) begin
            if (bus.pwm !== 4'b0011) bad++;
            if (bus.wrap !== ((k % 100) == 0)) wbad++;
            @(negedge clk);
        end
        checks++;
        if (tmo || bad != 0 || wbad != 0) begin
            errors++;
            $display("FAIL regs_unchanged got pwm_bad=%0d wrap_bad=%0d want 0 0", bad, wbad);
        end
    endtask

    task automatic test_write_at_commit();
        logic ok, err;
        int n;
        bit tmo;
        int bad = 0;
        // Entered on a wrap sample: cnt is 1 here, so the third strobe meets cnt == 99.
        repeat (96) @(negedge clk);
        send_frame(8'h02, 8'h00, 8'h32, ok, err);
        checks++;
        if (ok !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL commit_frame_ok got ok=%b err=%b want ok=1 err=0", ok, err);
        end
        wait_wrap(n, tmo);
        checks++;
        if (tmo || n != 1) begin
            errors++;
            $display("FAIL commit_alignment got %0d cycles to wrap want 1", n);
        end
        for (int k = 0; k < 200; k++) begin
            logic [3:0] exp;
            exp = (k >= 100 && k < 150) ? 4'b0111 : 4'b0011;
            if (bus.pwm !== exp) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL write_at_commit got %0d bad samples want 0", bad);
        end
    endtask

`ifdef PWM_BANK_TIMEOUT_EN
    task automatic test_timeout();
        logic ok, err;
        int ecnt = 0;
        bus.rx_dat = 8'h03;
        bus.rx_stb = 1'b1;
        @(negedge clk);
        bus.rx_stb = 1'b0;
        for (int k = 0; k < 1010; k++) begin
            @(negedge clk);
            if (bus.frm_err === 1'b1) ecnt++;
        end
        checks++;
        if (ecnt != 1) begin
            errors++;
            $display("FAIL timeout_err got %0d pulses want 1", ecnt);
        end
        send_frame(8'h03, 8'h00, 8'h00, ok, err);
        checks++;
        if (ok !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL after_timeout_ok got ok=%b err=%b want ok=1 err=0", ok, err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_duty_phase();
        test_period();
        test_invalid();
        test_write_at_commit();
`ifdef PWM_BANK_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
